// File: rtl/mem_slot_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_slot_sched                                                             |
// | Time-slotted arbiter sharing one SRAM between video, CPU and DMA.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mem_slot_sched #(
   parameter int STARVE_MAX = 4
) (
   input  logic        clk24,
   input  logic        reset,
   input  logic        ce3,

   input  logic        vid_req,
   input  logic [15:0] vid_addr,
   output logic        vid_valid,
   output logic [7:0]  vid_data,

   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_wdata,
   output logic        cpu_ack,
   output logic [7:0]  cpu_rdata,

   input  logic        dma_req,
   input  logic        dma_we,
   input  logic [15:0] dma_addr,
   input  logic [7:0]  dma_wdata,
   output logic        dma_ack,
   output logic [7:0]  dma_rdata,

   output logic [15:0] mem_addr,
   output logic [7:0]  mem_wdata,
   output logic        mem_oe,
   output logic        mem_we,
   input  logic [7:0]  mem_rdata,

   output logic [1:0]  owner
);

   localparam int       c_CNT_W    = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [1:0] c_OWN_NONE = 2'd0;
   localparam logic [1:0] c_OWN_VID  = 2'd1;
   localparam logic [1:0] c_OWN_CPU  = 2'd2;
   localparam logic [1:0] c_OWN_DMA  = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ADDR   = 3'd1,
      ST_STROBE = 3'd2,
      ST_CAPT   = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

   state_t               r_state;
   state_t               w_cur;
   state_t               w_next;
   logic [2:0]           r_phase;
   logic [c_CNT_W-1:0]   r_starve;
   logic [1:0]           r_owner;
   logic [15:0]          r_addr;
   logic                 r_we;
   logic [7:0]           r_wdata;
   logic [7:0]           r_vid_data;
   logic [7:0]           r_cpu_rdata;
   logic [7:0]           r_dma_rdata;

   logic                 w_arb;
   logic                 w_starved;
   logic [1:0]           w_win;
   logic [15:0]          w_win_addr;
   logic                 w_win_we;
   logic [7:0]           w_win_wdata;

   // The arbitration cycle itself is the ADDR slot, so the winner is decided
   // from the live request lines at phase 0 / phase 4.
   assign w_arb     = !reset && (r_state == ST_IDLE) &&
                      ((r_phase == 3'd0) || (r_phase == 3'd4));
   assign w_starved = (r_starve == c_CNT_W'(STARVE_MAX));

   always_comb begin
      w_win = c_OWN_NONE;
      if (!r_phase[2]) begin
         if (vid_req)      w_win = c_OWN_VID;
         else if (cpu_req) w_win = c_OWN_CPU;
         else if (dma_req) w_win = c_OWN_DMA;
      end else begin
         if (w_starved && dma_req) w_win = c_OWN_DMA;
         else if (cpu_req)         w_win = c_OWN_CPU;
         else if (dma_req)         w_win = c_OWN_DMA;
      end
   end

   always_comb begin
      w_win_addr  = 16'h0000;
      w_win_we    = 1'b0;
      w_win_wdata = 8'h00;
      case (w_win)
         c_OWN_VID: begin
            w_win_addr = vid_addr;
         end
         c_OWN_CPU: begin
            w_win_addr  = cpu_addr;
            w_win_we    = cpu_we;
            w_win_wdata = cpu_wdata;
         end
         c_OWN_DMA: begin
            w_win_addr  = dma_addr;
            w_win_we    = dma_we;
            w_win_wdata = dma_wdata;
         end
         default: begin
            w_win_addr = 16'h0000;
         end
      endcase
   end

   always_comb begin
      w_cur = r_state;
      if (w_arb && (w_win != c_OWN_NONE)) w_cur = ST_ADDR;
      w_next = ST_IDLE;
      case (w_cur)
         ST_ADDR:   w_next = ST_STROBE;
         ST_STROBE: w_next = ST_CAPT;
         ST_CAPT:   w_next = ST_DONE;
         default:   w_next = ST_IDLE;
      endcase
      // Frame sync restarts the slot grid; an unfinished access is dropped.
      if (ce3) w_next = ST_IDLE;
   end

   always_comb begin
      owner     = c_OWN_NONE;
      mem_addr  = 16'h0000;
      mem_wdata = 8'h00;
      mem_oe    = 1'b0;
      mem_we    = 1'b0;
      vid_valid = 1'b0;
      cpu_ack   = 1'b0;
      dma_ack   = 1'b0;
      case (w_cur)
         ST_ADDR: begin
            owner     = w_win;
            mem_addr  = w_win_addr;
            mem_wdata = w_win_we ? w_win_wdata : 8'h00;
         end
         ST_STROBE: begin
            owner     = r_owner;
            mem_addr  = r_addr;
            mem_wdata = r_we ? r_wdata : 8'h00;
            mem_oe    = !r_we;
            mem_we    = r_we;
         end
         ST_CAPT: begin
            owner     = r_owner;
            mem_addr  = r_addr;
            mem_wdata = r_we ? r_wdata : 8'h00;
            mem_oe    = !r_we;
         end
         ST_DONE: begin
            owner     = r_owner;
            mem_addr  = r_addr;
            vid_valid = (r_owner == c_OWN_VID);
            cpu_ack   = (r_owner == c_OWN_CPU);
            dma_ack   = (r_owner == c_OWN_DMA);
         end
         default: begin
            owner = c_OWN_NONE;
         end
      endcase
   end

   assign vid_data  = r_vid_data;
   assign cpu_rdata = r_cpu_rdata;
   assign dma_rdata = r_dma_rdata;

   always_ff @(posedge clk24) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_phase     <= 3'd0;
         r_starve    <= '0;
         r_owner     <= c_OWN_NONE;
         r_addr      <= 16'h0000;
         r_we        <= 1'b0;
         r_wdata     <= 8'h00;
         r_vid_data  <= 8'h00;
         r_cpu_rdata <= 8'h00;
         r_dma_rdata <= 8'h00;
      end else begin
         r_state <= w_next;
         r_phase <= ce3 ? 3'd0 : r_phase + 3'd1;

         if (w_cur == ST_ADDR) begin
            r_owner <= w_win;
            r_addr  <= w_win_addr;
            r_we    <= w_win_we;
            r_wdata <= w_win_wdata;
         end

         // Losing the video-preferred window is expected, so only window B
         // losses count toward starvation.
         if (w_arb) begin
            if (!dma_req || (w_win == c_OWN_DMA))
               r_starve <= '0;
            else if (r_phase[2] && !w_starved)
               r_starve <= r_starve + c_CNT_W'(1);
         end

         if ((w_cur == ST_CAPT) && !ce3 && !r_we) begin
            case (r_owner)
               c_OWN_VID: r_vid_data  <= mem_rdata;
               c_OWN_CPU: r_cpu_rdata <= mem_rdata;
               c_OWN_DMA: r_dma_rdata <= mem_rdata;
               default:   r_vid_data  <= r_vid_data;
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_slot_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mem_slot_sched                                                          |
// | Directed self-checking bench for the slotted SRAM arbiter.                 |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mem_slot_sched;

   logic        clk24 = 1'b0;
   logic        reset;
   logic        ce3;
   logic        vid_req, cpu_req, cpu_we, dma_req, dma_we;
   logic [15:0] vid_addr, cpu_addr, dma_addr, mem_addr;
   logic [7:0]  cpu_wdata, dma_wdata, mem_rdata, mem_wdata;
   logic [7:0]  vid_data, cpu_rdata, dma_rdata;
   logic        vid_valid, cpu_ack, dma_ack, mem_oe, mem_we;
   logic [1:0]  owner;

   int   tests = 0;
   int   fails = 0;
   int   ph = 0;
   logic ce3_auto = 1'b0;

   always #5 clk24 = ~clk24;

   mem_slot_sched #(.STARVE_MAX(4)) dut (
      .clk24     (clk24),
      .reset     (reset),
      .ce3       (ce3),
      .vid_req   (vid_req),
      .vid_addr  (vid_addr),
      .vid_valid (vid_valid),
      .vid_data  (vid_data),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_ack   (cpu_ack),
      .cpu_rdata (cpu_rdata),
      .dma_req   (dma_req),
      .dma_we    (dma_we),
      .dma_addr  (dma_addr),
      .dma_wdata (dma_wdata),
      .dma_ack   (dma_ack),
      .dma_rdata (dma_rdata),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_oe    (mem_oe),
      .mem_we    (mem_we),
      .mem_rdata (mem_rdata),
      .owner     (owner)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; ph tracks the phase the design is in after the edge.
   task automatic cyc();
      @(posedge clk24);
      if (reset || ce3) ph = 0;
      else              ph = (ph + 1) % 8;
      #2;
      ce3 = ce3_auto && (ph == 7);
   endtask

   task automatic run_to(input int p);
      int n = 0;
      do begin
         cyc();
         n++;
      end while ((ph != p) && (n < 16));
      if (ph != p) begin
         tests++;
         fails++;
         $error("FAIL run_to: phase %0d expected %0d", ph, p);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; ce3 = 1'b0;
      vid_req = 1'b0; vid_addr = 16'h0000;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
      dma_req = 1'b0; dma_we = 1'b0; dma_addr = 16'h0000; dma_wdata = 8'h00;
      mem_rdata = 8'h00;

      // Reset state, with a request pending that must not be granted
      cyc(); cyc();
      vid_req = 1'b1; vid_addr = 16'h8000;
      #1;
      chk("rst_owner", 32'(owner), 32'd0);
      chk("rst_addr", 32'(mem_addr), 32'h0);
      chk("rst_oe", 32'(mem_oe), 32'd0);
      chk("rst_we", 32'(mem_we), 32'd0);
      chk("rst_wdata", 32'(mem_wdata), 32'h0);
      chk("rst_vdata", 32'(vid_data), 32'h0);
      chk("rst_crdata", 32'(cpu_rdata), 32'h0);
      chk("rst_drdata", 32'(dma_rdata), 32'h0);
      chk("rst_acks", 32'({vid_valid, cpu_ack, dma_ack}), 32'd0);

      // Video read in window A, first arbitration right after release
      mem_rdata = 8'h5A; ce3_auto = 1'b1;
      cyc();
      reset = 1'b0;
      #1;
      chk("vid_p0_owner", 32'(owner), 32'd1);
      chk("vid_p0_addr", 32'(mem_addr), 32'h8000);
      chk("vid_p0_oe", 32'(mem_oe), 32'd0);
      cyc(); #1;
      chk("vid_p1_oe", 32'(mem_oe), 32'd1);
      chk("vid_p1_owner", 32'(owner), 32'd1);
      cyc(); #1;
      chk("vid_p2_oe", 32'(mem_oe), 32'd1);
      cyc();
      vid_req = 1'b0;
      #1;
      chk("vid_p3_valid", 32'(vid_valid), 32'd1);
      chk("vid_p3_data", 32'(vid_data), 32'h5A);
      chk("vid_p3_oe", 32'(mem_oe), 32'd0);
      chk("vid_p3_owner", 32'(owner), 32'd1);
      cyc(); #1;
      chk("vid_p4_owner", 32'(owner), 32'd0);
      chk("vid_p4_valid", 32'(vid_valid), 32'd0);
      chk("vid_p4_hold", 32'(vid_data), 32'h5A);

      // Video and CPU together: video takes A, CPU takes B
      run_to(0);
      vid_req = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1234;
      #1;
      chk("vc_p0_owner", 32'(owner), 32'd1);
      cyc();
      vid_req = 1'b0;
      run_to(4);
      mem_rdata = 8'hC3;
      #1;
      chk("vc_p4_owner", 32'(owner), 32'd2);
      chk("vc_p4_addr", 32'(mem_addr), 32'h1234);
      run_to(7);
      #1;
      chk("vc_p7_ack", 32'(cpu_ack), 32'd1);
      chk("vc_p7_rdata", 32'(cpu_rdata), 32'hC3);
      cpu_req = 1'b0;

      // CPU write in window B; request raised mid-window A must wait
      run_to(1);
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0100; cpu_wdata = 8'hA5;
      #1;
      chk("wr_p1_wait", 32'(owner), 32'd0);
      run_to(4); #1;
      chk("wr_p4_owner", 32'(owner), 32'd2);
      chk("wr_p4_wdata", 32'(mem_wdata), 32'hA5);
      chk("wr_p4_we", 32'(mem_we), 32'd0);
      chk("wr_p4_addr", 32'(mem_addr), 32'h0100);
      cyc();
      cpu_addr = 16'hFFFF; cpu_wdata = 8'h00;
      #1;
      chk("wr_p5_we", 32'(mem_we), 32'd1);
      chk("wr_p5_oe", 32'(mem_oe), 32'd0);
      chk("wr_p5_wdata", 32'(mem_wdata), 32'hA5);
      chk("wr_p5_addr", 32'(mem_addr), 32'h0100);
      cyc(); #1;
      chk("wr_p6_we", 32'(mem_we), 32'd0);
      chk("wr_p6_wdata", 32'(mem_wdata), 32'hA5);
      chk("wr_p6_oe", 32'(mem_oe), 32'd0);
      cyc(); #1;
      chk("wr_p7_ack", 32'(cpu_ack), 32'd1);
      chk("wr_p7_we", 32'(mem_we), 32'd0);
      chk("wr_p7_rdata", 32'(cpu_rdata), 32'hC3);
      cpu_req = 1'b0;

      // DMA starvation: four lost B windows, fifth B window forced to DMA
      run_to(0);
      vid_req = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1234;
      dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h4444; mem_rdata = 8'h77;
      #1;
      chk("st_a_owner", 32'(owner), 32'd1);
      for (int w = 1; w <= 5; w++) begin
         run_to(4); #1;
         chk($sformatf("st_b%0d_owner", w), 32'(owner), (w == 5) ? 32'd3 : 32'd2);
      end
      chk("st_b5_addr", 32'(mem_addr), 32'h4444);
      run_to(7); #1;
      chk("st_dma_ack", 32'(dma_ack), 32'd1);
      chk("st_dma_rdata", 32'(dma_rdata), 32'h77);
      chk("st_cpu_ack", 32'(cpu_ack), 32'd0);
      run_to(0); #1;
      chk("st_a_next", 32'(owner), 32'd1);
      run_to(4); #1;
      chk("st_cleared", 32'(owner), 32'd2);
      cyc();
      vid_req = 1'b0; cpu_req = 1'b0; dma_req = 1'b0;

      // Frame sync forced at phase 2 of a CPU read aborts it
      run_to(7);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h2222;
      run_to(0); #1;
      chk("ab_p0_owner", 32'(owner), 32'd2);
      chk("ab_p0_addr", 32'(mem_addr), 32'h2222);
      cyc(); cyc();
      mem_rdata = 8'h99;
      #1;
      chk("ab_p2_oe", 32'(mem_oe), 32'd1);
      ce3 = 1'b1;
      cyc(); #1;
      chk("ab_oe_drop", 32'(mem_oe), 32'd0);
      chk("ab_no_ack", 32'(cpu_ack), 32'd0);
      chk("ab_rdata_kept", 32'(cpu_rdata), 32'h77);
      chk("ab_regrant", 32'(owner), 32'd2);
      cyc(); #1;
      chk("ab_retry_oe", 32'(mem_oe), 32'd1);
      cyc(); cyc();
      cpu_req = 1'b0;
      dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h3333; dma_wdata = 8'h5C;
      #1;
      chk("ab_retry_ack", 32'(cpu_ack), 32'd1);
      chk("ab_retry_rdata", 32'(cpu_rdata), 32'h99);

      // Reset during STROBE of a DMA write
      run_to(4); #1;
      chk("rs_p4_owner", 32'(owner), 32'd3);
      chk("rs_p4_wdata", 32'(mem_wdata), 32'h5C);
      cyc(); #1;
      chk("rs_p5_we", 32'(mem_we), 32'd1);
      reset = 1'b1;
      cyc(); #1;
      chk("rs_we", 32'(mem_we), 32'd0);
      chk("rs_owner", 32'(owner), 32'd0);
      chk("rs_ack", 32'(dma_ack), 32'd0);
      chk("rs_addr", 32'(mem_addr), 32'h0);
      chk("rs_crdata", 32'(cpu_rdata), 32'h0);
      chk("rs_vdata", 32'(vid_data), 32'h0);
      cyc(); #1;
      chk("rs_hold_ack", 32'(dma_ack), 32'd0);
      chk("rs_hold_owner", 32'(owner), 32'd0);
      reset = 1'b0;
      #1;
      chk("rs_rel_owner", 32'(owner), 32'd3);
      chk("rs_rel_addr", 32'(mem_addr), 32'h3333);
      chk("rs_rel_wdata", 32'(mem_wdata), 32'h5C);
      cyc(); #1;
      chk("rs_rel_we", 32'(mem_we), 32'd1);
      cyc(); cyc(); #1;
      chk("rs_rel_ack", 32'(dma_ack), 32'd1);
      dma_req = 1'b0;
      cyc(); #1;
      chk("rs_end_owner", 32'(owner), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
